// File: rtl/intr_ctl.sv
// intr_ctl: parametrised interrupt controller for one I/O slot.
//
// Each source can be level or rising-edge sensitive, individually masked,
// and globally gated by gie. A CLAIM read returns the id+1 of the
// lowest-index enabled pending source and, in edge mode, clears it.
//
// Ports:
//   clk        system clock, all state updates on the rising edge
//   reset      asynchronous active-low reset
//   src        raw interrupt request lines, active high
//   io_addr    register word index
//   io_write   single-cycle write strobe
//   io_read    single-cycle read strobe (only CLAIM has a side effect)
//   io_wdata   write data
//   io_rdata   read data, combinational from io_addr
//   interrupt  registered interrupt request to the execute unit
//
// Register map (bits >= NSRC read 0, writes ignored):
//   0 PENDING (W1C on edge-mode bits)   1 ENABLE   2 MODE (1 = edge)
//   3 CLAIM (read only)   4 CTRL bit0 = gie   5 RAW (synchronised src)
module intr_ctl #(
    parameter int RV   = 16,
    parameter int NSRC = 8,
    parameter int SYNC = 2
) (
    input  logic            clk,
    input  logic            reset,
    input  logic [NSRC-1:0] src,
    input  logic [3:0]      io_addr,
    input  logic            io_write,
    input  logic            io_read,
    input  logic [RV-1:0]   io_wdata,
    output logic [RV-1:0]   io_rdata,
    output logic            interrupt
);

    logic [NSRC-1:0] s;
    logic [NSRC-1:0] hist_reg;
    logic [NSRC-1:0] pending_reg;
    logic [NSRC-1:0] pending_next;
    logic [NSRC-1:0] enable_reg;
    logic [NSRC-1:0] mode_reg;
    logic            gie_reg;
    logic            interrupt_reg;
    logic [RV-1:0]   claim_val;
    logic            w1c_strobe;
    logic            claim_strobe;
    logic            unused_wdata;

    // Upper write-data bits have no destination when NSRC < RV.
    assign unused_wdata = ^io_wdata;

    // Input synchroniser: s is src delayed by SYNC clocks.
    generate
        if (SYNC == 0) begin : g_nosync
            assign s = src;
        end else begin : g_sync
            logic [NSRC-1:0] sync_reg [SYNC];
            always_ff @(posedge clk or negedge reset) begin
                if (!reset) begin
                    for (int k = 0; k < SYNC; k++) sync_reg[k] <= '0;
                end else begin
                    sync_reg[0] <= src;
                    for (int k = 1; k < SYNC; k++) sync_reg[k] <= sync_reg[k-1];
                end
            end
            assign s = sync_reg[SYNC-1];
        end
    endgenerate

    // Lowest index wins; the scan runs high-to-low so the last hit is the
    // lowest enabled pending source.
    always_comb begin
        claim_val = '0;
        for (int i = NSRC - 1; i >= 0; i--) begin
            if (pending_reg[i] && enable_reg[i]) claim_val = RV'(i + 1);
        end
    end

    assign w1c_strobe   = io_write && (io_addr == 4'd0);
    assign claim_strobe = io_read  && (io_addr == 4'd3);

    // Per-source pending logic. Level sources simply track s; edge sources
    // latch a rising edge, and a set in the same cycle beats any clear.
    // A claim that returns 0 matches no source, so it clears nothing.
    generate
        for (genvar gi = 0; gi < NSRC; gi++) begin : g_src
            logic edge_set;
            logic edge_clr;
            assign edge_set = s[gi] & ~hist_reg[gi];
            assign edge_clr = (w1c_strobe & io_wdata[gi])
                            | (claim_strobe && (claim_val == RV'(gi + 1)));
            assign pending_next[gi] = mode_reg[gi]
                                    ? (edge_set | (pending_reg[gi] & ~edge_clr))
                                    : s[gi];
        end
    endgenerate

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            hist_reg      <= '0;
            pending_reg   <= '0;
            enable_reg    <= '0;
            mode_reg      <= '0;
            gie_reg       <= 1'b0;
            interrupt_reg <= 1'b0;
        end else begin
            hist_reg      <= s;
            pending_reg   <= pending_next;
            interrupt_reg <= gie_reg & |(pending_reg & enable_reg);
            if (io_write) begin
                case (io_addr)
                    4'd1:    enable_reg <= io_wdata[NSRC-1:0];
                    4'd2:    mode_reg   <= io_wdata[NSRC-1:0];
                    4'd4:    gie_reg    <= io_wdata[0];
                    default: ;
                endcase
            end
        end
    end

    always_comb begin
        io_rdata = '0;
        case (io_addr)
            4'd0:    io_rdata[NSRC-1:0] = pending_reg;
            4'd1:    io_rdata[NSRC-1:0] = enable_reg;
            4'd2:    io_rdata[NSRC-1:0] = mode_reg;
            4'd3:    io_rdata           = claim_val;
            4'd4:    io_rdata[0]        = gie_reg;
            4'd5:    io_rdata[NSRC-1:0] = s;
            default: io_rdata           = '0;
        endcase
    end

    assign interrupt = interrupt_reg;

endmodule
